// File: rtl/FPU_pkg.sv
// rtl/FPU_pkg.sv - FPU operation codes shared by floating-point blocks
package FPU_pkg;
    localparam logic [4:0] FPU_OP_MIN = 5'd6;
    localparam logic [4:0] FPU_OP_MAX = 5'd7;
endpackage

// File: rtl/fp_selector_fifo.sv
// rtl/fp_selector_fifo.sv - IEEE-754 MIN/MAX selector feeding an output result FIFO
// Optional MINMAG/MAXMAG support is enabled with macro FP_SELECTOR_MAG_EN.
module fp_selector_fifo
    import FPU_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       valid_in,
    output logic                       ready_out,
    input  logic [4:0]                 op,
    input  logic                       mag,
    input  logic [EXP_W+MAN_W:0]       a,
    input  logic [EXP_W+MAN_W:0]       b,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [EXP_W+MAN_W:0]       float_out,
    output logic                       IV
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic a_nan, b_nan, a_snan, b_snan;
    logic a_lt_b, ops_eq, is_max;
    logic [W-1:0] result;
    logic         result_iv;

    assign a_nan  = (&a[W-2:MAN_W]) && (|a[MAN_W-1:0]);
    assign b_nan  = (&b[W-2:MAN_W]) && (|b[MAN_W-1:0]);
    assign a_snan = a_nan && !a[MAN_W-1];
    assign b_snan = b_nan && !b[MAN_W-1];
    assign is_max = (op == FPU_OP_MAX);
    assign result_iv = a_snan || b_snan;

`ifndef FP_SELECTOR_MAG_EN
    logic unused_mag;
    assign unused_mag = mag;
`endif

    // Sign-magnitude ordering: a negative value is below any positive one, so -0 < +0.
    always_comb begin
        ops_eq = 1'b0;
        a_lt_b = 1'b0;
`ifdef FP_SELECTOR_MAG_EN
        if (mag) begin
            ops_eq = (a[W-2:0] == b[W-2:0]);
            a_lt_b = (a[W-2:0] <  b[W-2:0]);
        end else
`endif
        if (a[W-1] != b[W-1]) begin
            a_lt_b = a[W-1];
        end else begin
            ops_eq = (a[W-2:0] == b[W-2:0]);
            a_lt_b = a[W-1] ? (a[W-2:0] > b[W-2:0]) : (a[W-2:0] < b[W-2:0]);
        end
    end

    always_comb begin
        result = a;
        if (a_nan && b_nan) begin
            result = QNAN;
        end else if (a_nan) begin
            result = b;
        end else if (b_nan) begin
            result = a;
        end else if (ops_eq) begin
            result = {(is_max ? (a[W-1] & b[W-1]) : (a[W-1] | b[W-1])), a[W-2:0]};
        end else begin
            result = (a_lt_b ^ is_max) ? a : b;
        end
    end

    logic [W:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, empty, op_ok, push, pop;
    logic [W:0]       head;

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign op_ok     = (op == FPU_OP_MIN) || (op == FPU_OP_MAX);
    assign ready_out = !full && op_ok;
    assign valid_out = !empty;
    assign push      = valid_in && ready_out && !flush;
    assign pop       = valid_out && ready_in && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset: every read of it is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {result, result_iv};
    end

    assign head      = mem[rd_ptr];
    assign float_out = empty ? '0 : head[W:1];
    assign IV        = !empty && head[0];

endmodule

// File: tb/tb_fp_selector_fifo.sv
// tb/tb_fp_selector_fifo.sv - randomized scoreboard bench for fp_selector_fifo
module tb_fp_selector_fifo;
    import FPU_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush, valid_in, ready_in, mag;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        ready_out, valid_out, IV;
    logic [31:0] float_out;

    logic        flush64, valid_in64, ready_in64, mag64;
    logic [4:0]  op64;
    logic [63:0] a64, b64;
    logic        ready_out64, valid_out64, IV64;
    logic [63:0] float_out64;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fp_selector_fifo #(.EXP_W(8), .MAN_W(23), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .valid_in(valid_in),
        .ready_out(ready_out), .op(op), .mag(mag), .a(a), .b(b),
        .valid_out(valid_out), .ready_in(ready_in), .float_out(float_out), .IV(IV)
    );

    fp_selector_fifo #(.EXP_W(11), .MAN_W(52), .DEPTH(2)) u_dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush64), .valid_in(valid_in64),
        .ready_out(ready_out64), .op(op64), .mag(mag64), .a(a64), .b(b64),
        .valid_out(valid_out64), .ready_in(ready_in64), .float_out(float_out64), .IV(IV64)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic bit op_ok(input logic [4:0] o);
        return (o == FPU_OP_MIN) || (o == FPU_OP_MAX);
    endfunction

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hff) && (x[22:0] != 0);
    endfunction

    // Reference: map each operand onto an integer number line and pick by comparison.
    function automatic logic [32:0] ref_sel(input logic [31:0] x, input logic [31:0] y,
                                            input logic [4:0] o, input logic m);
        longint kx, ky;
        logic [31:0] r;
        bit use_mag, iv;
        use_mag = 1'b0;
`ifdef FP_SELECTOR_MAG_EN
        use_mag = m;
`else
        if (m) use_mag = 1'b0;
`endif
        iv = (is_nan(x) && !x[22]) || (is_nan(y) && !y[22]);
        if (use_mag) begin
            kx = longint'(x[30:0]);
            ky = longint'(y[30:0]);
        end else begin
            kx = x[31] ? -longint'(x[30:0]) - 1 : longint'(x[30:0]);
            ky = y[31] ? -longint'(y[30:0]) - 1 : longint'(y[30:0]);
        end
        if (is_nan(x) && is_nan(y))   r = 32'h7fc00000;
        else if (is_nan(x))           r = y;
        else if (is_nan(y))           r = x;
        else if (kx == ky)            r = (o == FPU_OP_MAX) ? {x[31] & y[31], x[30:0]}
                                                            : {x[31] | y[31], x[30:0]};
        else if (o == FPU_OP_MAX)     r = (kx > ky) ? x : y;
        else                          r = (kx < ky) ? x : y;
        return {r, iv};
    endfunction

    logic [32:0] q[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            bit do_pop, do_push;
            do_pop  = (q.size() > 0) && ready_in;
            do_push = valid_in && (q.size() < DEPTH) && op_ok(op);
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(ref_sel(a, b, op, mag));
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("valid_out", valid_out, q.size() != 0);
            check("ready_out", ready_out, (q.size() < DEPTH) && op_ok(op));
            if (q.size() != 0) begin
                check("float_out", float_out, q[0][32:1]);
                check("IV", IV, q[0][0]);
            end else begin
                check("float_out_empty", float_out, 0);
                check("IV_empty", IV, 0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic directed(input string name, input logic [4:0] o, input logic m,
                            input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] exp_r, input logic exp_iv);
        valid_in = 1'b1; ready_in = 1'b0; op = o; mag = m; a = x; b = y;
        step();
        valid_in = 1'b0;
        check({name, "_valid"}, valid_out, 1);
        check({name, "_res"}, float_out, exp_r);
        check({name, "_iv"}, IV, exp_iv);
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return {r[31], 8'hff, 23'h0};
            3: return {r[31], 8'hff, 1'b1, r[21:0]};
            4: return {r[31], 8'hff, 1'b0, r[21:0] | 22'h1};
            5: return {r[31], 8'h7f, r[22:20], 20'h0};
            default: return r;
        endcase
    endfunction

    initial begin
        reset_n = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        op = FPU_OP_MIN; mag = 1'b0; a = '0; b = '0;
        flush64 = 1'b0; valid_in64 = 1'b0; ready_in64 = 1'b0;
        op64 = FPU_OP_MIN; mag64 = 1'b0; a64 = '0; b64 = '0;
        #1;
        check("rst_valid_out", valid_out, 0);
        check("rst_float_out", float_out, 0);
        check("rst_IV", IV, 0);
        check("rst_ready_out", ready_out, 1);

        check("model_min", ref_sel(32'h3f800000, 32'hc0000000, FPU_OP_MIN, 1'b0), {32'hc0000000, 1'b0});
        check("model_snan", ref_sel(32'h7f800001, 32'h3f800000, FPU_OP_MAX, 1'b0), {32'h3f800000, 1'b1});
        check("model_zero_max", ref_sel(32'h00000000, 32'h80000000, FPU_OP_MAX, 1'b0), {32'h00000000, 1'b0});
        check("model_neg_min", ref_sel(32'hc0400000, 32'hc0000000, FPU_OP_MIN, 1'b0), {32'hc0400000, 1'b0});

        step();
        reset_n = 1'b1;
        step();

        directed("min_basic", FPU_OP_MIN, 1'b0, 32'h3f800000, 32'hc0000000, 32'hc0000000, 1'b0);
        directed("max_snan",  FPU_OP_MAX, 1'b0, 32'h7f800001, 32'h3f800000, 32'h3f800000, 1'b1);
        directed("min_qs",    FPU_OP_MIN, 1'b0, 32'h7fc00000, 32'h7f800001, 32'h7fc00000, 1'b1);
        directed("min_zero",  FPU_OP_MIN, 1'b0, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0);
        directed("max_zero",  FPU_OP_MAX, 1'b0, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0);
        directed("max_neg",   FPU_OP_MAX, 1'b0, 32'hc0400000, 32'hc0000000, 32'hc0000000, 1'b0);

        // Fill to full with the consumer stalled, then pop/push across the pointer wrap.
        ready_in = 1'b0; valid_in = 1'b1; op = FPU_OP_MAX;
        for (int i = 0; i < DEPTH; i++) begin
            a = 32'h3f800000 + i; b = 32'h3f800000;
            step();
        end
        check("full_ready_out", ready_out, 0);
        check("full_head", float_out, 32'h3f800000);
        a = 32'h40000000; b = 32'h00000000; ready_in = 1'b1;
        step();
        check("after_pop_ready", ready_out, 1);
        step();
        valid_in = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) step();
        ready_in = 1'b0;
        check("drained", valid_out, 0);

        // Flush with a concurrent push drops everything.
        valid_in = 1'b1; op = FPU_OP_MIN; a = 32'h3f800000; b = 32'h40000000;
        step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0; valid_in = 1'b0;
        check("flush_valid_out", valid_out, 0);

        valid_in = 1'b1;
        step(); step();
        valid_in = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", valid_out, 0);
        check("rst_mid_float", float_out, 0);
        check("rst_mid_IV", IV, 0);
        step();
        reset_n = 1'b1;
        step();
        directed("post_reset", FPU_OP_MAX, 1'b0, 32'hbf800000, 32'h3f800000, 32'h3f800000, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            ready_in = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 63) == 0);
            op       = ($urandom_range(0, 7) == 0) ? 5'd31
                     : ($urandom_range(0, 1) ? FPU_OP_MAX : FPU_OP_MIN);
            mag      = $urandom_range(0, 1);
            a        = rand_fp();
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = a ^ 32'h80000000;
                default: b = rand_fp();
            endcase
            step();
        end
        flush = 1'b0; valid_in = 1'b0;

        valid_in64 = 1'b1; op64 = FPU_OP_MIN; mag64 = 1'b1;
        a64 = 64'hc000000000000000; b64 = 64'h3ff0000000000000;
        step();
        valid_in64 = 1'b0;
        check("d64_valid", valid_out64, 1);
`ifdef FP_SELECTOR_MAG_EN
        check("d64_minmag", float_out64, 64'h3ff0000000000000);
`else
        check("d64_min", float_out64, 64'hc000000000000000);
`endif
        check("d64_iv", IV64, 0);
        ready_in64 = 1'b1;
        step();
        ready_in64 = 1'b0;
        check("d64_empty", valid_out64, 0);
        valid_in64 = 1'b1; a64 = 64'h7ff0000000000001; b64 = 64'h7ff8000000000000;
        step();
        valid_in64 = 1'b0;
        check("d64_qnan", float_out64, 64'h7ff8000000000000);
        check("d64_qnan_iv", IV64, 1);
        ready_in64 = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
